// File: rtl/score_tracker.sv
// score_tracker: live score counter with tick prescaler, circular history of
// finished-game scores and a descending top-NUM_HS high-score table.
// Optional build macro SCORE_TRACKER_BCD_EN adds a 6-digit BCD mirror of the
// score on output score_bcd, saturating at 999999.
module score_tracker #(
    parameter int CLOCK_FREQUENCY = 25000000,
    parameter int TICKS_PER_SEC   = 10,
    parameter int SCORE_WIDTH     = 32,
    parameter int HIST_DEPTH      = 256,
    parameter int NUM_HS          = 4
) (
    input  logic                          Clock,
    input  logic                          reset,
    input  logic                          run,
    input  logic                          pause,
    input  logic                          clear,
    input  logic                          commit,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_rd_idx,
    input  logic [$clog2(NUM_HS):0]       hs_rd_idx,
    output logic [SCORE_WIDTH-1:0]        score,
    output logic [SCORE_WIDTH-1:0]        hist_rd_data,
    output logic [SCORE_WIDTH-1:0]        hs_rd_data,
    output logic [$clog2(HIST_DEPTH):0]   hist_count,
    output logic                          busy,
    output logic                          new_best
`ifdef SCORE_TRACKER_BCD_EN
    ,
    output logic [23:0]                   score_bcd
`endif
);

    localparam int TICK_MAX = CLOCK_FREQUENCY / TICKS_PER_SEC - 1;
    localparam int PRE_W    = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam int HIST_AW  = $clog2(HIST_DEPTH);
    localparam int CNT_W    = HIST_AW + 1;
    localparam int STEP_W   = $clog2(NUM_HS + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOG, S_INSERT, S_DONE} state_t;

    state_t                   state;
    logic [PRE_W-1:0]         prescaler;
    logic [SCORE_WIDTH-1:0]   snap;
    logic [SCORE_WIDTH-1:0]   hist [HIST_DEPTH];
    logic [SCORE_WIDTH-1:0]   hs   [NUM_HS];
    logic [HIST_AW-1:0]       wr_ptr;
    logic [HIST_AW-1:0]       rd_addr;
    logic [STEP_W-1:0]        step;
    logic                     settled;
    logic                     best_hit;
    logic [SCORE_WIDTH-1:0]   hs_cur;
    logic                     idle;
    logic                     place;

    // Saturating increment: the score never wraps back to zero.
    function automatic logic [SCORE_WIDTH-1:0] sat_inc(input logic [SCORE_WIDTH-1:0] v);
        return (&v) ? v : v + SCORE_WIDTH'(1);
    endfunction

`ifdef SCORE_TRACKER_BCD_EN
    // Six-digit BCD increment with decimal carry, holding at 999999.
    function automatic logic [23:0] bcd_inc(input logic [23:0] v);
        logic [23:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        if (v == 24'h999999) return v;
        for (int d = 0; d < 6; d++) begin
            if (c) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction
`endif

    assign idle    = (state == S_IDLE);
    assign rd_addr = wr_ptr - HIST_AW'(1) - hist_rd_idx;
    assign place   = !settled && (snap > hs_cur);

    // Select the high-score entry examined by the current insertion step.
    always_comb begin
        hs_cur = '0;
        for (int k = 0; k < NUM_HS; k++) begin
            if (int'(step) == k) hs_cur = hs[k];
        end
    end

    // Combinational high-score read; out-of-range indices read zero.
    always_comb begin
        hs_rd_data = '0;
        for (int k = 0; k < NUM_HS; k++) begin
            if (int'(hs_rd_idx) == k) hs_rd_data = hs[k];
        end
    end

    // Score counter and prescaler: clear beats commit beats tick; frozen while busy.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            score     <= '0;
            prescaler <= PRE_W'(TICK_MAX);
`ifdef SCORE_TRACKER_BCD_EN
            score_bcd <= '0;
`endif
        end else if (clear) begin
            score <= '0;
`ifdef SCORE_TRACKER_BCD_EN
            score_bcd <= '0;
`endif
            // A clear during a commit only zeroes the score.
            if (idle) prescaler <= PRE_W'(TICK_MAX);
        end else if (idle && !commit && run && !pause) begin
            if (prescaler == '0) begin
                prescaler <= PRE_W'(TICK_MAX);
                score     <= sat_inc(score);
`ifdef SCORE_TRACKER_BCD_EN
                score_bcd <= bcd_inc(score_bcd);
`endif
            end else begin
                prescaler <= prescaler - PRE_W'(1);
            end
        end
    end

    // Commit FSM: log the snapshot into history, then walk the high-score table.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            new_best   <= 1'b0;
            snap       <= '0;
            wr_ptr     <= '0;
            hist_count <= '0;
            step       <= '0;
            settled    <= 1'b0;
            best_hit   <= 1'b0;
            for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
            for (int k = 0; k < NUM_HS; k++) hs[k] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    new_best <= 1'b0;
                    if (commit) begin
                        // A same-cycle clear wins, so the game is logged as zero.
                        snap  <= clear ? '0 : score;
                        busy  <= 1'b1;
                        state <= S_LOG;
                    end
                end
                S_LOG: begin
                    hist[wr_ptr] <= snap;
                    wr_ptr       <= wr_ptr + HIST_AW'(1);
                    if (hist_count != CNT_W'(HIST_DEPTH)) hist_count <= hist_count + CNT_W'(1);
                    step     <= '0;
                    settled  <= 1'b0;
                    best_hit <= 1'b0;
                    state    <= S_INSERT;
                end
                S_INSERT: begin
                    // Equal scores end the walk: a score already in the table is not duplicated.
                    if (place) begin
                        for (int j = 0; j < NUM_HS; j++) begin
                            if (j == int'(step)) hs[j] <= snap;
                            else if (j > int'(step)) hs[j] <= hs[(j > 0) ? j - 1 : 0];
                        end
                        settled <= 1'b1;
                        if (step == '0) best_hit <= 1'b1;
                    end else if (!settled && snap == hs_cur) begin
                        settled <= 1'b1;
                    end
                    if (step == STEP_W'(NUM_HS - 1)) begin
                        new_best <= best_hit | (place && step == '0);
                        state    <= S_DONE;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                S_DONE: begin
                    new_best <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Registered history read, newest-first; slots beyond hist_count read zero.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            hist_rd_data <= '0;
        end else if ({1'b0, hist_rd_idx} < hist_count) begin
            hist_rd_data <= hist[rd_addr];
        end else begin
            hist_rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker: small prescaler, 4-bit score, 4-deep history.
module tb_score_tracker;
    localparam int CF = 100;
    localparam int TPS = 10;
    localparam int SW = 4;
    localparam int HD = 4;
    localparam int NH = 4;

    logic          Clock = 1'b0;
    logic          reset = 1'b0;
    logic          run = 1'b0;
    logic          pause = 1'b0;
    logic          clear = 1'b0;
    logic          commit = 1'b0;
    logic [1:0]    hist_rd_idx = '0;
    logic [2:0]    hs_rd_idx = '0;
    logic [SW-1:0] score;
    logic [SW-1:0] hist_rd_data;
    logic [SW-1:0] hs_rd_data;
    logic [2:0]    hist_count;
    logic          busy;
    logic          new_best;

    int            errors = 0;
    int            checks = 0;
    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] hist_m[$];
    logic [SW-1:0] hs_m[NH];
    logic [SW-1:0] score_m = '0;

    score_tracker #(
        .CLOCK_FREQUENCY(CF),
        .TICKS_PER_SEC(TPS),
        .SCORE_WIDTH(SW),
        .HIST_DEPTH(HD),
        .NUM_HS(NH)
    ) dut (
        .Clock(Clock),
        .reset(reset),
        .run(run),
        .pause(pause),
        .clear(clear),
        .commit(commit),
        .hist_rd_idx(hist_rd_idx),
        .hs_rd_idx(hs_rd_idx),
        .score(score),
        .hist_rd_data(hist_rd_data),
        .hs_rd_data(hs_rd_data),
        .hist_count(hist_count),
        .busy(busy),
        .new_best(new_best)
    );

    always #5 Clock = ~Clock;

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference table update: first strictly smaller entry takes the score; an equal entry blocks it.
    task automatic model_insert(input logic [SW-1:0] s, output logic nb);
        nb = 1'b0;
        for (int k = 0; k < NH; k++) begin
            if (s == hs_m[k]) break;
            if (s > hs_m[k]) begin
                for (int j = NH - 1; j > k; j--) hs_m[j] = hs_m[j-1];
                hs_m[k] = s;
                nb = (k == 0);
                break;
            end
        end
    endtask

    task automatic set_score(input int v);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        run = 1'b1;
        step(v * (CF / TPS));
        run = 1'b0;
        score_m = SW'(v);
        check("set_score", score, score_m);
    endtask

    task automatic do_commit(input int hold, input logic with_clear);
        logic [SW-1:0] snap;
        logic          nb_exp;
        logic          nb_seen;
        int            cnt;
        snap = with_clear ? '0 : score_m;
        exp_q.push_back(snap);
        hist_m.push_front(snap);
        if (hist_m.size() > HD) void'(hist_m.pop_back());
        model_insert(snap, nb_exp);
        commit = 1'b1;
        clear = with_clear;
        cnt = 0;
        nb_seen = 1'b0;
        do begin
            step(1);
            cnt++;
            clear = 1'b0;
            if (cnt >= hold) commit = 1'b0;
            nb_seen |= new_best;
        end while (busy && cnt < 40);
        commit = 1'b0;
        check("busy_latency", cnt, NH + 3);
        check("new_best", nb_seen, nb_exp);
        if (with_clear) score_m = '0;
        check("score_after_commit", score, score_m);
        hist_rd_idx = '0;
        step(1);
        check("hist_newest", hist_rd_data, exp_q.pop_front());
    endtask

    task automatic check_table();
        for (int k = 0; k < 8; k++) begin
            hs_rd_idx = 3'(k);
            step(1);
            check($sformatf("hs[%0d]", k), hs_rd_data, (k < NH) ? hs_m[k] : '0);
        end
    endtask

    task automatic check_hist();
        check("hist_count", hist_count, hist_m.size());
        for (int i = 0; i < HD; i++) begin
            hist_rd_idx = 2'(i);
            step(1);
            check($sformatf("hist[%0d]", i), hist_rd_data, (i < hist_m.size()) ? hist_m[i] : '0);
        end
    endtask

    initial begin
        for (int k = 0; k < NH; k++) hs_m[k] = '0;
        step(3);
        check("rst_score", score, 0);
        check("rst_busy", busy, 0);
        check("rst_new_best", new_best, 0);
        check("rst_hist_count", hist_count, 0);
        check("rst_hs0", hs_rd_data, 0);
        reset = 1'b1;
        step(1);
        check("rst_hist_data", hist_rd_data, 0);

        // First tick lands exactly TICK_MAX+1 cycles after run rises.
        run = 1'b1;
        step(9);
        check("tick_early", score, 0);
        step(1);
        check("tick_first", score, 1);
        step(90);
        check("score_100cyc", score, 10);
        pause = 1'b1;
        step(50);
        check("score_paused", score, 10);
        pause = 1'b0;
        run = 1'b0;

        // Commit held two cycles: the second cycle must be ignored.
        set_score(5);
        do_commit(2, 1'b0);
        check_hist();
        foreach (hs_m[k]) begin end
        set_score(9);
        do_commit(1, 1'b0);
        set_score(7);
        do_commit(1, 1'b0);
        set_score(9);
        do_commit(1, 1'b0);
        set_score(3);
        do_commit(1, 1'b0);
        check_table();
        check_hist();

        // Clear and commit together: logged as zero, history wraps.
        set_score(6);
        do_commit(1, 1'b1);
        check_hist();
        check_table();

        // Reset while the table walk is in progress.
        set_score(12);
        commit = 1'b1;
        step(1);
        commit = 1'b0;
        step(3);
        check("busy_in_insert", busy, 1);
        reset = 1'b0;
        #2;
        check("midrst_busy", busy, 0);
        check("midrst_score", score, 0);
        check("midrst_count", hist_count, 0);
        reset = 1'b1;
        for (int k = 0; k < NH; k++) hs_m[k] = '0;
        hist_m.delete();
        exp_q.delete();
        score_m = '0;
        step(1);
        check_table();
        check_hist();

        // Saturation at all-ones.
        set_score(15);
        run = 1'b1;
        step(30);
        run = 1'b0;
        check("score_saturated", score, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
